// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction fetch and IF/ID register with stall, flush, branch, halt and fault handling.
module pc_fetch_unit #(
    parameter int          MEM_BYTES   = 100,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] HALT_OPCODE = 16'hF000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    input  logic [15:0] i_instr_in,
    output logic [15:0] o_pointer,
    output logic [15:0] o_ifid_instr,
    output logic [15:0] o_ifid_pc,
    output logic [15:0] o_ifid_pc_plus2,
    output logic        o_ifid_valid,
    output logic        o_halted,
    output logic        o_fetch_fault
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
    localparam logic [15:0] LAST = 16'(MEM_BYTES - 2);
    state_t      r_state, w_state_nx;
    logic [15:0] r_pc, w_pc_nx, r_instr, r_ifpc, r_ifpc2;
    logic        r_valid, w_hold, w_capture, w_tgt_bad, w_pc_bad;
    assign w_tgt_bad = i_branch_target[0] | (i_branch_target > LAST);
    assign w_pc_bad  = r_pc[0] | (r_pc > LAST);
    // IF/ID loads a bubble whenever neither hold nor capture is selected
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_hold     = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            RUN: begin
                if (i_branch_taken) begin
                    if (w_tgt_bad) w_state_nx = FAULT;
                    else w_pc_nx = i_branch_target;
                end else if (w_pc_bad) begin
                    w_state_nx = FAULT;
                end else if (i_stall) begin
                    w_hold = !i_flush;
                end else if (i_flush) begin
                    w_pc_nx = r_pc + 16'd2;
                end else begin
                    w_capture = 1'b1;
                    if (i_instr_in == HALT_OPCODE) w_state_nx = HALT;
                    else w_pc_nx = r_pc + 16'd2;
                end
            end
            HALT: begin
                w_hold = i_stall & !i_flush;
                if (i_branch_taken) begin
                    w_hold = 1'b0;
                    if (w_tgt_bad) w_state_nx = FAULT;
                    else begin
                        w_pc_nx    = i_branch_target;
                        w_state_nx = RUN;
                    end
                end
            end
            default: w_hold = i_stall & !i_flush;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_ifpc  <= '0;
            r_ifpc2 <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            if (!w_hold) begin
                r_instr <= w_capture ? i_instr_in : '0;
                r_ifpc  <= w_capture ? r_pc : '0;
                r_ifpc2 <= w_capture ? r_pc + 16'd2 : '0;
                r_valid <= w_capture;
            end
        end
    end
    assign o_pointer       = r_pc;
    assign o_ifid_instr    = r_instr;
    assign o_ifid_pc       = r_ifpc;
    assign o_ifid_pc_plus2 = r_ifpc2;
    assign o_ifid_valid    = r_valid;
    assign o_halted        = (r_state == HALT);
    assign o_fetch_fault   = (r_state == FAULT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven directed test of pc_fetch_unit against a combinational instruction memory.
module tb_pc_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, br = 1'b0;
    logic [15:0] tgt = '0, instr;
    logic [15:0] ptr, if_instr, if_pc, if_pc2;
    logic        if_valid, halted, fault;
    logic [15:0] mem [0:49];
    int          checks = 0, errors = 0;

    typedef struct {
        logic        rst_pre, stall, flush, br;
        logic [15:0] tgt, ptr, instr, pc;
        logic        valid, halted, fault;
    } vec_t;
    vec_t v [0:21];

    pc_fetch_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(br), .i_branch_target(tgt), .i_instr_in(instr),
        .o_pointer(ptr), .o_ifid_instr(if_instr), .o_ifid_pc(if_pc),
        .o_ifid_pc_plus2(if_pc2), .o_ifid_valid(if_valid),
        .o_halted(halted), .o_fetch_fault(fault)
    );

    always #5 clk = ~clk;
    always_comb instr = (ptr < 16'd100) ? mem[ptr[6:1]] : 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_ptr, input logic [15:0] e_instr,
                             input logic [15:0] e_pc, input logic e_valid, input logic e_halted,
                             input logic e_fault);
        check({tag, ".pointer"}, ptr, e_ptr);
        check({tag, ".instr"}, if_instr, e_instr);
        check({tag, ".pc"}, if_pc, e_pc);
        check({tag, ".pc_plus2"}, if_pc2, e_valid ? e_pc + 16'd2 : 16'h0);
        check({tag, ".valid"}, {15'd0, if_valid}, {15'd0, e_valid});
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, e_halted});
        check({tag, ".fault"}, {15'd0, fault}, {15'd0, e_fault});
    endtask

    initial begin
        for (int i = 0; i < 50; i++) mem[i] = 16'h1000 + 16'(i * 2);
        mem[0] = 16'h0E20; mem[1] = 16'h0B21; mem[2] = 16'h2388;
        mem[31] = 16'hF000; mem[49] = 16'h0000;
        //        rst  st  fl  br  tgt       ptr       instr     pc        v  h  f
        v[0]  = '{0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0E20, 16'h0000, 1, 0, 0};
        v[1]  = '{0, 0, 0, 0, 16'h0000, 16'h0004, 16'h0B21, 16'h0002, 1, 0, 0};
        v[2]  = '{0, 1, 0, 0, 16'h0000, 16'h0004, 16'h0B21, 16'h0002, 1, 0, 0};
        v[3]  = '{0, 1, 0, 0, 16'h0000, 16'h0004, 16'h0B21, 16'h0002, 1, 0, 0};
        v[4]  = '{0, 0, 0, 0, 16'h0000, 16'h0006, 16'h2388, 16'h0004, 1, 0, 0};
        v[5]  = '{0, 0, 0, 0, 16'h0000, 16'h0008, 16'h1006, 16'h0006, 1, 0, 0};
        v[6]  = '{0, 1, 1, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0, 0};
        v[7]  = '{0, 0, 1, 0, 16'h0000, 16'h000A, 16'h0000, 16'h0000, 0, 0, 0};
        v[8]  = '{0, 0, 0, 0, 16'h0000, 16'h000C, 16'h100A, 16'h000A, 1, 0, 0};
        v[9]  = '{0, 1, 0, 1, 16'h003E, 16'h003E, 16'h0000, 16'h0000, 0, 0, 0};
        v[10] = '{0, 0, 0, 0, 16'h0000, 16'h003E, 16'hF000, 16'h003E, 1, 1, 0};
        v[11] = '{0, 0, 0, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0000, 0, 1, 0};
        v[12] = '{0, 1, 0, 0, 16'h0000, 16'h003E, 16'h0000, 16'h0000, 0, 1, 0};
        v[13] = '{0, 0, 0, 1, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0};
        v[14] = '{0, 0, 0, 0, 16'h0000, 16'h0004, 16'h0B21, 16'h0002, 1, 0, 0};
        v[15] = '{0, 0, 0, 1, 16'h0062, 16'h0062, 16'h0000, 16'h0000, 0, 0, 0};
        v[16] = '{0, 0, 0, 0, 16'h0000, 16'h0064, 16'h0000, 16'h0062, 1, 0, 0};
        v[17] = '{0, 0, 0, 0, 16'h0000, 16'h0064, 16'h0000, 16'h0000, 0, 0, 1};
        v[18] = '{0, 0, 0, 1, 16'h0004, 16'h0064, 16'h0000, 16'h0000, 0, 0, 1};
        v[19] = '{0, 0, 1, 0, 16'h0000, 16'h0064, 16'h0000, 16'h0000, 0, 0, 1};
        v[20] = '{1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0E20, 16'h0000, 1, 0, 0};
        v[21] = '{0, 0, 0, 1, 16'h0005, 16'h0002, 16'h0000, 16'h0000, 0, 0, 1};

        #1 check_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (v[i].rst_pre) begin
                @(negedge clk) rst_n = 1'b0;
                #1 check_all($sformatf("rst%0d", i), 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
                rst_n = 1'b1;
            end
            stall = v[i].stall; flush = v[i].flush; br = v[i].br; tgt = v[i].tgt;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), v[i].ptr, v[i].instr, v[i].pc, v[i].valid, v[i].halted, v[i].fault);
        end
        // Fetch a few instructions, then assert reset between edges: outputs clear with no clock edge.
        stall = 0; flush = 0; br = 0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 check_all("pre_async", 16'h0004, 16'h0B21, 16'h0002, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("resume", 16'h0002, 16'h0E20, 16'h0000, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch stage that owns the program counter, drives the byte address into the instruction memory and registers the returned 16-bit instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory (its `pointer` output is that memory's `pointer` input) and directly upstream of decode (IF/ID outputs). It handles stall, flush, branch redirect, halt detection and out-of-range/misaligned fetch faults.

## Interface
- `MEM_BYTES`, 100: instruction memory size in bytes; valid fetch addresses are 0 to MEM_BYTES-2, even only.
- `RESET_PC`, 16'h0000: PC value on reset.
- `HALT_OPCODE`, 16'hF000: instruction word that halts fetch.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC and IF/ID.
- `flush` in 1: load a bubble into IF/ID.
- `branch_taken` in 1: redirect PC to `branch_target`.
- `branch_target` in 16: byte address of the redirect.
- `instr_in` in 16: combinational instruction-memory output for `pointer`.
- `pointer` out 16: registered PC, fed to instruction memory.
- `ifid_instr` out 16: captured instruction.
- `ifid_pc` out 16: address of `ifid_instr`.
- `ifid_pc_plus2` out 16: `ifid_pc`+2, mod 2^16.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: FSM in HALT.
- `fetch_fault` out 1: FSM in FAULT.

## Operation
- FSM states: RUN, HALT, FAULT. `halted` is (state==HALT). `fetch_fault` is (state==FAULT).
- Reset, asynchronous while `rst`=0:
  - `pointer`=RESET_PC, state=RUN.
  - `ifid_instr`, `ifid_pc`, `ifid_pc_plus2` = 0; `ifid_valid`=0.
- Bubble means instr=0, pc=0, pc_plus2=0, valid=0.
- RUN, priority highest first, evaluated at each edge:
  1. `branch_taken`: if `branch_target` is odd or greater than MEM_BYTES-2, go to FAULT and load a bubble with PC unchanged. Otherwise PC=`branch_target` and load a bubble. This overrides `stall` and `flush`.
  2. `pointer` is odd or greater than MEM_BYTES-2: go to FAULT, load a bubble, PC holds.
  3. `stall`: PC holds. IF/ID holds, unless `flush`=1, in which case load a bubble.
  4. `flush`: load a bubble; PC=PC+2.
  5. Normal fetch: IF/ID = {`instr_in`, `pointer`, `pointer`+2, 1}. If `instr_in`==HALT_OPCODE, PC holds and state goes to HALT. Otherwise PC=PC+2.
- HALT:
  - PC holds.
  - IF/ID holds if `stall`=1 and `flush`=0; otherwise load a bubble.
  - `branch_taken` with a valid target: PC=target, bubble, return to RUN. The halt was wrong-path.
  - `branch_taken` with an invalid target: go to FAULT.
- FAULT: PC holds. IF/ID loads a bubble each cycle unless `stall`=1 and `flush`=0. All other inputs are ignored. Only reset exits.
- Arithmetic: all PC math is 16-bit and wraps mod 2^16. Wrap is unreachable in practice because of the range check.

## Timing
- `pointer` is a register. The instruction memory is combinational, so `instr_in` for a PC is captured at the next rising edge: 1-cycle latency from PC to IF/ID.
- Sequential fetch throughput: one instruction per cycle.
- Redirect penalty: after a taken branch, the first valid IF/ID appears 2 edges later. The edge that takes the branch loads the bubble; the next edge captures the target instruction.
- Halt: the halt word is visible in IF/ID with `ifid_valid`=1 for exactly one cycle (absent stall). `halted` rises at the same edge it is captured.
- `stall` and `flush` are sampled only at rising edges. No combinational path from any input to any output.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for `clk`. Fetch resumes from RESET_PC on the first edge after release.

## Test plan
- Reset, then run 3 cycles with the team program loaded: IF/ID = (0x0E20, pc 0), (0x0B21, pc 2), (0x2388, pc 4), all valid. `pointer` = 6.
- `stall` held 2 cycles at `pointer`=4: IF/ID stays (0x0B21, pc 2) and `pointer` stays 4. After release, the next IF/ID is (0x2388, pc 4).
- `branch_taken` with target 0x003E while `stall`=1: the bubble overrides the stall. The next edge captures 0xF000 valid at pc 0x3E with `halted`=1. The following edge gives a bubble and `pointer` stays 0x3E.
- In HALT, `branch_taken` to 0x0002: RUN resumes and `halted`=0. After 2 edges IF/ID = (0x0B21, pc 2).
- Fault cases, each from RUN:
  - `branch_taken` to 0x0005: `fetch_fault`=1, bubble, `pointer` unchanged.
  - `branch_taken` to 0x0062 (98): 0x0000 is captured valid at pc 98. The next edge with `pointer`=100 sets `fetch_fault`=1.
  - Any further input: `fetch_fault` stays 1.
- `flush` and `stall` together at `pointer`=8: IF/ID becomes a bubble and `pointer` stays 8. Then deassert `rst` after a mid-cycle assert: outputs are 0 and `pointer`=0 asynchronously.
